// File: rtl/control_sequencer.sv
// control_sequencer: Moore control unit for the CPU datapath.
// It runs the fetch steps, then the execute steps for register-register, unary and MUL/DIV instructions.
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [13:0] dp_ctl,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic [12:0] alu_sel,
    output logic        halted,
    output logic [3:0]  state
);
    // state | meaning
    // IDLE  | waiting for run at an instruction boundary
    // T0-T2 | fetch: PC to MAR, memory read (held on mem_ready), MDR to IR
    // T3-T6 | execute steps of the decoded instruction class
    // HALT  | parked until clr
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        HALT = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_BIN,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_HALT
    } cls_t;

    localparam int unsigned DP_INCPC  = 13;
    localparam int unsigned DP_READ   = 12;
    localparam int unsigned DP_IRIN   = 10;
    localparam int unsigned DP_YIN    = 9;
    localparam int unsigned DP_ZIN    = 8;
    localparam int unsigned DP_MARIN  = 7;
    localparam int unsigned DP_MDRIN  = 6;
    localparam int unsigned DP_LOIN   = 5;
    localparam int unsigned DP_HIIN   = 4;
    localparam int unsigned DP_ZLOW   = 3;
    localparam int unsigned DP_ZHIGH  = 2;
    localparam int unsigned DP_MDROUT = 1;
    localparam int unsigned DP_PCOUT  = 0;

    state_t      state_q, state_d, done_state;
    cls_t        cls;
    logic [12:0] alu_op;
    logic [4:0]  opcode;
    logic [15:0] ra_oh, rb_oh, rc_oh;

    assign opcode = ir[31:27];
    assign ra_oh  = 16'h0001 << ir[26:23];
    assign rb_oh  = 16'h0001 << ir[22:19];
    assign rc_oh  = 16'h0001 << ir[18:15];

    // Anything not listed, including the explicit nop opcode, falls into CLS_NOP.
    always_comb begin
        cls    = CLS_NOP;
        alu_op = '0;
        case (opcode)
            5'b00011: begin cls = CLS_BIN;    alu_op[2]  = 1'b1; end
            5'b00100: begin cls = CLS_BIN;    alu_op[3]  = 1'b1; end
            5'b00101: begin cls = CLS_BIN;    alu_op[0]  = 1'b1; end
            5'b00110: begin cls = CLS_BIN;    alu_op[1]  = 1'b1; end
            5'b00111: begin cls = CLS_BIN;    alu_op[8]  = 1'b1; end
            5'b01000: begin cls = CLS_BIN;    alu_op[9]  = 1'b1; end
            5'b01001: begin cls = CLS_BIN;    alu_op[6]  = 1'b1; end
            5'b01010: begin cls = CLS_BIN;    alu_op[12] = 1'b1; end
            5'b01011: begin cls = CLS_BIN;    alu_op[7]  = 1'b1; end
            5'b01111: begin cls = CLS_MULDIV; alu_op[4]  = 1'b1; end
            5'b10000: begin cls = CLS_MULDIV; alu_op[5]  = 1'b1; end
            5'b10001: begin cls = CLS_UNARY;  alu_op[10] = 1'b1; end
            5'b10010: begin cls = CLS_UNARY;  alu_op[11] = 1'b1; end
            5'b11011: cls = CLS_HALT;
            default:  cls = CLS_NOP;
        endcase
    end

    assign done_state = run ? T0 : IDLE;

    always_comb begin
        state_d = IDLE;
        dp_ctl  = '0;
        reg_in  = '0;
        reg_out = '0;
        alu_sel = '0;
        case (state_q)
            IDLE: state_d = run ? T0 : IDLE;
            T0: begin
                dp_ctl[DP_PCOUT] = 1'b1;
                dp_ctl[DP_MARIN] = 1'b1;
                dp_ctl[DP_INCPC] = 1'b1;
                state_d          = T1;
            end
            T1: begin
                dp_ctl[DP_READ]  = 1'b1;
                dp_ctl[DP_MDRIN] = 1'b1;
                state_d          = mem_ready ? T2 : T1;
            end
            T2: begin
                dp_ctl[DP_MDROUT] = 1'b1;
                dp_ctl[DP_IRIN]   = 1'b1;
                state_d           = T3;
            end
            T3: begin
                case (cls)
                    CLS_BIN: begin
                        reg_out        = rb_oh;
                        dp_ctl[DP_YIN] = 1'b1;
                        state_d        = T4;
                    end
                    CLS_UNARY: begin
                        reg_out        = rb_oh;
                        alu_sel        = alu_op;
                        dp_ctl[DP_ZIN] = 1'b1;
                        state_d        = T4;
                    end
                    CLS_MULDIV: begin
                        reg_out        = ra_oh;
                        dp_ctl[DP_YIN] = 1'b1;
                        state_d        = T4;
                    end
                    CLS_HALT: state_d = HALT;
                    default:  state_d = done_state;
                endcase
            end
            T4: begin
                case (cls)
                    CLS_BIN: begin
                        reg_out        = rc_oh;
                        alu_sel        = alu_op;
                        dp_ctl[DP_ZIN] = 1'b1;
                        state_d        = T5;
                    end
                    CLS_UNARY: begin
                        dp_ctl[DP_ZLOW] = 1'b1;
                        reg_in          = ra_oh;
                        state_d         = done_state;
                    end
                    CLS_MULDIV: begin
                        reg_out        = rb_oh;
                        alu_sel        = alu_op;
                        dp_ctl[DP_ZIN] = 1'b1;
                        state_d        = T5;
                    end
                    default: state_d = done_state;
                endcase
            end
            T5: begin
                case (cls)
                    CLS_BIN: begin
                        dp_ctl[DP_ZLOW] = 1'b1;
                        reg_in          = ra_oh;
                        state_d         = done_state;
                    end
                    CLS_MULDIV: begin
                        dp_ctl[DP_ZLOW] = 1'b1;
                        dp_ctl[DP_LOIN] = 1'b1;
                        state_d         = T6;
                    end
                    default: state_d = done_state;
                endcase
            end
            T6: begin
                if (cls == CLS_MULDIV) begin
                    dp_ctl[DP_ZHIGH] = 1'b1;
                    dp_ctl[DP_HIIN]  = 1'b1;
                end
                state_d = done_state;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign state  = state_q;
    assign halted = (state_q == HALT);

endmodule
